// File: rtl/store_ctrl_pkg.sv
// Shared definitions for the store sequencer and the store-size merge unit.
//   - 3-bit state encoding of the store read-modify-write FSM
//   - store-size codes, used both as store_kind and as ss_control
//   - is_rmw(): true for the kinds that need the target word read first
package store_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [1:0] SS_NONE = 2'b00;
  localparam logic [1:0] SS_B    = 2'b01;
  localparam logic [1:0] SS_H    = 2'b10;
  localparam logic [1:0] SS_W    = 2'b11;

  // Byte and halfword stores must merge into the existing word.
  function automatic logic is_rmw(input logic [1:0] kind);
    return (kind == SS_B) || (kind == SS_H);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that paces the memory read latency.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over en)
//   load_val   : value loaded on load
//   en         : decrement by one; holds at zero instead of wrapping
//   zero       : count is zero
module mem_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/store_rmw_ctrl.sv
// Sequencer for partial-word stores in the multicycle datapath.
// SB/SH read the target word into MemDataReg, then write back the word
// merged by the store-size unit; SW writes B directly; kind 00 completes
// immediately with err.
//   clk, reset  : clock, synchronous active-high reset
//   start       : store request, sampled only in IDLE
//   store_kind  : 01=SB 10=SH 11=SW 00=illegal, sampled with start
//   busy        : high in every state except IDLE
//   done, err   : one-cycle completion pulse; err with done for kind 00
//   mem_rd      : memory read strobe
//   mdr_load    : MemDataReg load enable
//   mem_wr      : memory write strobe
//   ss_control  : merge-unit select, latched kind while busy, 00 in IDLE
// All outputs are decoded from state and the latched kind only.
module store_rmw_ctrl
  import store_ctrl_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] store_kind,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       mem_rd,
  output logic       mdr_load,
  output logic       mem_wr,
  output logic [1:0] ss_control
);

  // WAIT is entered with MEM_RD_LAT-1 and left when the count reads zero,
  // so it lasts exactly MEM_RD_LAT cycles.
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_RD_LAT - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [1:0] kind_q;
  logic       cnt_load;
  logic       cnt_en;
  logic       cnt_zero;

  assign cnt_load = (state == ST_RD);
  assign cnt_en   = (state == ST_WAIT);

  mem_wait_counter #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_INIT),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // State and latched kind. The kind is captured only when a request is
  // accepted, so later changes on store_kind cannot disturb ss_control.
  // NOTE: clocked state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      kind_q <= SS_NONE;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start) begin
        kind_q <= store_kind;
      end
    end
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_rmw(store_kind))          state_nxt = ST_RD;
          else if (store_kind == SS_W)     state_nxt = ST_WRITE;
          else                             state_nxt = ST_DONE;
        end
      end
      ST_RD:    state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt_zero) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore output decode; one strobe per state keeps mem_rd, mdr_load and
  // mem_wr mutually exclusive by construction.
  always_comb begin
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    err        = 1'b0;
    mem_rd     = 1'b0;
    mdr_load   = 1'b0;
    mem_wr     = 1'b0;
    ss_control = SS_NONE;
    if (state != ST_IDLE) begin
      ss_control = kind_q;
    end
    case (state)
      ST_RD:    mem_rd   = 1'b1;
      ST_LATCH: mdr_load = 1'b1;
      ST_WRITE: mem_wr   = 1'b1;
      ST_DONE: begin
        done = 1'b1;
        err  = (kind_q == SS_NONE);
      end
      default: ;
    endcase
  end

endmodule
